// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the 5-stage RV32I pipeline.
package pipe_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Instruction addresses are always word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order FIFO buffering instruction words between memory responses and Decode.
// Clear beats push/pop; push into a full queue is legal when a pop frees the slot.
module fetch_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop & (count != '0);
    assign do_push = push & ((count != CW'(DEPTH)) | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Data storage needs no reset: head is only consumed while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC generation, request/grant/response memory port and fetch queue.
// Optional bubble counter port BubbleCnt enabled by defining FETCH_BUBBLE_CNT_EN.
module fetch_stage
    import pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallF,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
`ifdef FETCH_BUBBLE_CNT_EN
    output logic [XLEN-1:0] BubbleCnt,
`endif
    output logic            InstrValidF
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned SW = CW + 1;

    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] del_pc;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] head;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic            pop;
    logic            push;
    logic            room;
    logic            grant;

    assign target      = word_align(PCTargetE);
    assign InstrValidF = (count != '0);
    assign pop         = InstrValidF & ~StallF & ~PCSrcE;
    // Requests in flight plus buffered words must never exceed the queue depth.
    assign room        = (SW'(outstanding) + SW'(count) - SW'(pop)) < SW'(QDEPTH);
    assign imem_req    = room & ~PCSrcE & rst_n;
    assign imem_addr   = req_pc;
    assign grant       = imem_req & imem_gnt;
    assign push        = imem_rvalid & (discard == '0) & ~PCSrcE;

    assign Instr   = InstrValidF ? head : NOP_INSTR;
    assign PC      = del_pc;
    assign PCPlus4 = del_pc + XLEN'(4);

    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (XLEN)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (PCSrcE),
        .wdata (imem_rdata),
        .head  (head),
        .count (count)
    );

    // A redirect retargets both PCs and marks every still-unanswered request as stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_pc      <= RESET_PC;
            del_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (PCSrcE) begin
            req_pc      <= target;
            del_pc      <= target;
            outstanding <= outstanding - CW'(imem_rvalid);
            discard     <= outstanding - CW'(imem_rvalid);
        end else begin
            if (grant) req_pc <= req_pc + XLEN'(4);
            if (pop)   del_pc <= del_pc + XLEN'(4);
            outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);
            if (imem_rvalid && (discard != '0)) discard <= discard - CW'(1);
        end
    end

`ifdef FETCH_BUBBLE_CNT_EN
    // Saturating count of cycles Decode receives no instruction while not stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BubbleCnt <= '0;
        end else if (!InstrValidF && !StallF && (BubbleCnt != '1)) begin
            BubbleCnt <= BubbleCnt + XLEN'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural instruction memory of configurable latency.
// Define FETCH_BUBBLE_CNT_EN to also exercise BubbleCnt.
module tb_fetch_stage;

    localparam int unsigned QD = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        StallF = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        InstrValidF;
`ifdef FETCH_BUBBLE_CNT_EN
    logic [31:0] BubbleCnt;
`endif

    int checks = 0;
    int errors = 0;

    // Memory model state
    int          lat = 1;
    bit          rand_gnt = 1'b0;
    int          cyc = 0;
    int          max_pend = 0;
    int          n_grant = 0;
    int          n_resp = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (QD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .StallF      (StallF),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .Instr       (Instr),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
`ifdef FETCH_BUBBLE_CNT_EN
        .BubbleCnt   (BubbleCnt),
`endif
        .InstrValidF (InstrValidF)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0033;
    endfunction

    // Handshake captured mid-cycle; responses driven just after the following edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend_addr.delete();
                pend_due.delete();
                n_grant = 0;
                n_resp = 0;
            end else if (imem_req && imem_gnt) begin
                pend_addr.push_back(imem_addr);
                pend_due.push_back(cyc + lat);
                n_grant++;
                if (pend_addr.size() > max_pend) max_pend = pend_addr.size();
            end
            @(posedge clk);
            #1;
            cyc++;
            if (rst_n && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                assert (n_resp < n_grant) else $error("memory responded without a grant");
                n_resp++;
                imem_rvalid = 1'b1;
                imem_rdata = instr_of(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                imem_rvalid = 1'b0;
            end
            imem_gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic do_reset(input int l, input bit rg);
        to_drive();
        rst_n = 1'b0;
        StallF = 1'b0;
        PCSrcE = 1'b0;
        PCTargetE = '0;
        lat = l;
        rand_gnt = rg;
        to_drive();
        to_drive();
        max_pend = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        to_drive();
        rst_n = 1'b0;
        to_sample();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
        checks++; if (InstrValidF !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", InstrValidF); end
        checks++; if (Instr !== NOP) begin errors++; $display("FAIL rst_instr: got %h want %h", Instr, NOP); end
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", PC); end
        checks++; if (PCPlus4 !== 32'h4) begin errors++; $display("FAIL rst_pcplus4: got %h want 4", PCPlus4); end
`ifdef FETCH_BUBBLE_CNT_EN
        checks++; if (BubbleCnt !== 32'h0) begin errors++; $display("FAIL rst_bubble: got %0d want 0", BubbleCnt); end
`endif
    endtask

    // Zero-wait memory: requests 0,4,8 back to back, first instruction two cycles after release.
    task automatic test_startup();
        do_reset(1, 1'b0);
        to_sample();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL start_c0: req %b addr %h want 1 0", imem_req, imem_addr); end
        to_drive(); to_sample();
        checks++; if (imem_addr !== 32'h4 || InstrValidF !== 1'b0) begin errors++; $display("FAIL start_c1: addr %h valid %b want 4 0", imem_addr, InstrValidF); end
        to_drive(); to_sample();
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL start_c2_addr: got %h want 8", imem_addr); end
        checks++; if (InstrValidF !== 1'b1 || PC !== 32'h0 || Instr !== instr_of(32'h0) || PCPlus4 !== 32'h4) begin
            errors++; $display("FAIL start_first: valid %b pc %h instr %h pc4 %h want 1 0 %h 4", InstrValidF, PC, Instr, PCPlus4, instr_of(32'h0));
        end
`ifdef FETCH_BUBBLE_CNT_EN
        checks++; if (BubbleCnt !== 32'd2) begin errors++; $display("FAIL start_bubble: got %0d want 2", BubbleCnt); end
`endif
        for (int k = 1; k <= 6; k++) begin
            to_drive(); to_sample();
            checks++;
            if (InstrValidF !== 1'b1 || PC !== 32'(4 * k) || Instr !== instr_of(32'(4 * k)) || PCPlus4 !== 32'(4 * k + 4)) begin
                errors++; $display("FAIL stream_%0d: valid %b pc %h instr %h pc4 %h want pc %h", k, InstrValidF, PC, Instr, PCPlus4, 32'(4 * k));
            end
        end
`ifdef FETCH_BUBBLE_CNT_EN
        checks++; if (BubbleCnt !== 32'd2) begin errors++; $display("FAIL stream_bubble: got %0d want 2", BubbleCnt); end
`endif
    endtask

    // Continues from the stream: stall three cycles at PC 0x1C with the queue filling up.
    task automatic test_stall();
        for (int k = 0; k < 3; k++) begin
            to_drive(); StallF = 1'b1; to_sample();
            checks++;
            if (imem_req !== 1'b0 || InstrValidF !== 1'b1 || PC !== 32'h1C || Instr !== instr_of(32'h1C)) begin
                errors++; $display("FAIL stall_%0d: req %b valid %b pc %h instr %h want 0 1 1c", k, imem_req, InstrValidF, PC, Instr);
            end
        end
        to_drive(); StallF = 1'b0; to_sample();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h24 || PC !== 32'h1C) begin
            errors++; $display("FAIL stall_resume: req %b addr %h pc %h want 1 24 1c", imem_req, imem_addr, PC);
        end
        for (int k = 0; k < 3; k++) begin
            to_drive(); to_sample();
            checks++;
            if (InstrValidF !== 1'b1 || PC !== 32'(32'h20 + 4 * k) || Instr !== instr_of(32'(32'h20 + 4 * k))) begin
                errors++; $display("FAIL stall_after_%0d: valid %b pc %h want %h", k, InstrValidF, PC, 32'(32'h20 + 4 * k));
            end
        end
    endtask

    // Three-cycle memory: redirect while two requests are in flight; both answers must be dropped.
    task automatic test_redirect();
        do_reset(3, 1'b0);
        to_sample();
        to_drive(); to_sample();
        to_drive(); PCSrcE = 1'b1; PCTargetE = 32'h0000_0103; to_sample();
        checks++; if (imem_req !== 1'b0 || InstrValidF !== 1'b0) begin errors++; $display("FAIL redir_n: req %b valid %b want 0 0", imem_req, InstrValidF); end
        to_drive(); PCSrcE = 1'b0; to_sample();
        checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b0 || InstrValidF !== 1'b0) begin
            errors++; $display("FAIL redir_n1: addr %h req %b valid %b want 100 0 0", imem_addr, imem_req, InstrValidF);
        end
        for (int k = 4; k <= 7; k++) begin
            to_drive(); to_sample();
            checks++; if (InstrValidF !== 1'b0 || Instr !== NOP) begin errors++; $display("FAIL redir_stale_c%0d: valid %b instr %h want 0 nop", k, InstrValidF, Instr); end
        end
        to_drive(); to_sample();
        checks++; if (InstrValidF !== 1'b1 || PC !== 32'h100 || Instr !== instr_of(32'h100)) begin
            errors++; $display("FAIL redir_target: valid %b pc %h instr %h want 1 100 %h", InstrValidF, PC, Instr, instr_of(32'h100));
        end
`ifdef FETCH_BUBBLE_CNT_EN
        checks++; if (BubbleCnt !== 32'd8) begin errors++; $display("FAIL redir_bubble: got %0d want 8", BubbleCnt); end
`endif
        to_drive(); to_sample();
        checks++; if (PC !== 32'h104 || Instr !== instr_of(32'h104)) begin errors++; $display("FAIL redir_next: pc %h want 104", PC); end
    endtask

    // Zero-wait: redirect in the same cycle a response arrives; the target must not be dropped.
    task automatic test_redirect_rvalid();
        do_reset(1, 1'b0);
        for (int k = 0; k < 4; k++) to_drive();
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0200;
        to_sample();
        checks++; if (imem_rvalid !== 1'b1 || imem_req !== 1'b0 || PC !== 32'h8) begin
            errors++; $display("FAIL coinc_n: rvalid %b req %b pc %h want 1 0 8", imem_rvalid, imem_req, PC);
        end
        to_drive(); PCSrcE = 1'b0; to_sample();
        checks++; if (InstrValidF !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            errors++; $display("FAIL coinc_n1: valid %b req %b addr %h want 0 1 200", InstrValidF, imem_req, imem_addr);
        end
        to_drive(); to_sample();
        checks++; if (InstrValidF !== 1'b0 || imem_rvalid !== 1'b1) begin errors++; $display("FAIL coinc_n2: valid %b rvalid %b want 0 1", InstrValidF, imem_rvalid); end
        to_drive(); to_sample();
        checks++; if (InstrValidF !== 1'b1 || PC !== 32'h200 || Instr !== instr_of(32'h200)) begin
            errors++; $display("FAIL coinc_target: valid %b pc %h instr %h want 1 200", InstrValidF, PC, Instr);
        end
        to_drive(); to_sample();
        checks++; if (PC !== 32'h204) begin errors++; $display("FAIL coinc_next: pc %h want 204", PC); end
    endtask

    // Two redirects on consecutive cycles: only the second target is fetched.
    task automatic test_back_to_back();
        to_drive(); PCSrcE = 1'b1; PCTargetE = 32'h0000_0300;
        to_drive(); PCTargetE = 32'h0000_0402; to_sample();
        checks++; if (InstrValidF !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL b2b_n1: valid %b req %b want 0 0", InstrValidF, imem_req); end
        to_drive(); PCSrcE = 1'b0; to_sample();
        checks++; if (imem_addr !== 32'h400 || imem_req !== 1'b1 || InstrValidF !== 1'b0) begin
            errors++; $display("FAIL b2b_req: addr %h req %b valid %b want 400 1 0", imem_addr, imem_req, InstrValidF);
        end
        to_drive(); to_sample();
        checks++; if (InstrValidF !== 1'b0) begin errors++; $display("FAIL b2b_gap: valid %b want 0", InstrValidF); end
        to_drive(); to_sample();
        checks++; if (InstrValidF !== 1'b1 || PC !== 32'h400 || Instr !== instr_of(32'h400)) begin
            errors++; $display("FAIL b2b_target: valid %b pc %h instr %h want 1 400", InstrValidF, PC, Instr);
        end
        to_drive(); to_sample();
        checks++; if (PC !== 32'h404) begin errors++; $display("FAIL b2b_next: pc %h want 404", PC); end
    endtask

    // Address wrap from 0xFFFF_FFFC to 0.
    task automatic test_wrap();
        to_drive(); PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFF;
        to_drive(); PCSrcE = 1'b0; to_sample();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req: req %b addr %h want 1 fffffffc", imem_req, imem_addr); end
        to_drive(); to_sample();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
        to_drive(); to_sample();
        checks++; if (InstrValidF !== 1'b1 || PC !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0 || Instr !== instr_of(32'hFFFF_FFFC)) begin
            errors++; $display("FAIL wrap_head: valid %b pc %h pc4 %h want 1 fffffffc 0", InstrValidF, PC, PCPlus4);
        end
        to_drive(); to_sample();
        checks++; if (PC !== 32'h0 || Instr !== instr_of(32'h0)) begin errors++; $display("FAIL wrap_next: pc %h want 0", PC); end
    endtask

    // Reset while streaming must clear state without waiting for a clock edge.
    task automatic test_mid_reset();
        to_drive(); to_drive();
        rst_n = 1'b0;
        #1;
        checks++; if (InstrValidF !== 1'b0 || imem_req !== 1'b0 || PC !== 32'h0 || Instr !== NOP) begin
            errors++; $display("FAIL mid_reset: valid %b req %b pc %h instr %h want 0 0 0 nop", InstrValidF, imem_req, PC, Instr);
        end
    endtask

    // Three-cycle memory with random grants and random stalls.
    task automatic test_random_latency();
        logic [31:0] exp_pc;
        int pops;
        exp_pc = 32'h0;
        pops = 0;
        do_reset(3, 1'b1);
        for (int k = 0; k < 300; k++) begin
            to_drive();
            StallF = ($urandom_range(0, 3) == 0);
            to_sample();
            if (InstrValidF && !StallF) begin
                checks++;
                if (PC !== exp_pc || Instr !== instr_of(exp_pc)) begin
                    errors++; $display("FAIL rand_seq: pc %h instr %h want %h %h", PC, Instr, exp_pc, instr_of(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
        end
        StallF = 1'b0;
        checks++; if (max_pend > int'(QD) || max_pend < 1) begin errors++; $display("FAIL rand_outstanding: max %0d want 1..%0d", max_pend, QD); end
        checks++; if (pops < 30) begin errors++; $display("FAIL rand_progress: delivered %0d want >= 30", pops); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_startup();
        test_stall();
        test_redirect();
        test_redirect_rvalid();
        test_back_to_back();
        test_wrap();
        test_mid_reset();
        test_random_latency();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
